// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   state_t      : controller states (IDLE, RUN, DONE)
//   MULT_WIDTH   : default operand width
//   MULT_CNT_W   : iteration counter width for the default operand width
//   cnt_width()  : counter width for an arbitrary operand width
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MULT_WIDTH = 32;
    localparam int MULT_CNT_W = $clog2(MULT_WIDTH) + 1;

    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/mult_cycle_counter.sv
// Iteration counter for the multiplier.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset (count -> 0)
//   clr   : synchronous clear (wins over en)
//   en    : increment by one
//   tc    : terminal count, high while the count equals WIDTH-1
module mult_cycle_counter
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int CNT_W = MULT_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/seq_multiplier32.sv
// Iterative shift-add multiplier feeding the 32-bit result register.
// One product bit per RUN cycle; the full product is registered on the
// last RUN edge and held until the next operation completes.
// Optional feature macro: MULT_SIGNED_EN (adds signed_op and signed mode).
// Ports:
//   clk, reset              : clock, asynchronous active-high reset
//   start                   : request, only honoured in IDLE
//   multiplicand/multiplier : operands, captured on the accepting edge
//   signed_op               : signed request (MULT_SIGNED_EN builds only)
//   busy                    : high in RUN and DONE
//   done                    : one-cycle strobe, product valid
//   product                 : full 2*WIDTH product
//   result_lo               : low word of product, to the result register
//   overflow                : product does not fit in WIDTH bits
module seq_multiplier32
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
`ifdef MULT_SIGNED_EN
    input  logic               signed_op,
`endif
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   result_lo,
    output logic               overflow
);

    state_t               state_q, state_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplr_q, mplr_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic                 neg_q, neg_d;
    logic                 sgn_q, sgn_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 ovf_q, ovf_d;

    logic                 cnt_clr, cnt_en, cnt_tc;
    logic                 a_neg, b_neg, sgn_in;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   raw, fin;
    logic                 ovf_fin;

    // Signed mode works on magnitudes; the sign is reapplied at the end.
`ifdef MULT_SIGNED_EN
    assign sgn_in = signed_op;
    assign a_neg  = signed_op & multiplicand[WIDTH-1];
    assign b_neg  = signed_op & multiplier[WIDTH-1];
    assign a_mag  = a_neg ? -multiplicand : multiplicand;
    assign b_mag  = b_neg ? -multiplier : multiplier;
`else
    assign sgn_in = 1'b0;
    assign a_neg  = 1'b0;
    assign b_neg  = 1'b0;
    assign a_mag  = multiplicand;
    assign b_mag  = multiplier;
`endif

    mult_cycle_counter #(
        .WIDTH (WIDTH),
        .CNT_W (cnt_width(WIDTH))
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tc    (cnt_tc)
    );

    always_comb begin
        // Carry-out of the WIDTH+1 bit add lands in the accumulator MSB.
        sum     = {1'b0, acc_q} + (mplr_q[0] ? {1'b0, mcand_q} : '0);
        raw     = {sum, mplr_q[WIDTH-1:1]};
        fin     = neg_q ? -raw : raw;
        ovf_fin = sgn_q ? (fin[2*WIDTH-1:WIDTH] != {WIDTH{fin[WIDTH-1]}})
                        : (|fin[2*WIDTH-1:WIDTH]);

        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        mcand_d   = mcand_q;
        mplr_d    = mplr_q;
        acc_d     = acc_q;
        neg_d     = neg_q;
        sgn_d     = sgn_q;
        product_d = product_q;
        ovf_d     = ovf_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    mcand_d = a_mag;
                    mplr_d  = b_mag;
                    acc_d   = '0;
                    neg_d   = a_neg ^ b_neg;
                    sgn_d   = sgn_in;
                    cnt_clr = 1'b1;
                end
            end
            RUN: begin
                acc_d  = raw[2*WIDTH-1:WIDTH];
                mplr_d = raw[WIDTH-1:0];
                cnt_en = 1'b1;
                if (cnt_tc) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    product_d = fin;
                    ovf_d     = ovf_fin;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            mcand_q   <= '0;
            mplr_q    <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            sgn_q     <= 1'b0;
            product_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            mcand_q   <= mcand_d;
            mplr_q    <= mplr_d;
            acc_q     <= acc_d;
            neg_q     <= neg_d;
            sgn_q     <= sgn_d;
            product_q <= product_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign product   = product_q;
    assign result_lo = product_q[WIDTH-1:0];
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_seq_multiplier32.sv
// Self-checking bench for seq_multiplier32 (vector table + scoreboard).
module tb_seq_multiplier32;

    localparam int WIDTH = 32;

    logic               clk;
    logic               reset;
    logic               start;
    logic [WIDTH-1:0]   multiplicand;
    logic [WIDTH-1:0]   multiplier;
`ifdef MULT_SIGNED_EN
    logic               signed_op;
`endif
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   result_lo;
    logic               overflow;

    seq_multiplier32 dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
`ifdef MULT_SIGNED_EN
        .signed_op    (signed_op),
`endif
        .busy         (busy),
        .done         (done),
        .product      (product),
        .result_lo    (result_lo),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0]   a;
        logic [WIDTH-1:0]   b;
        logic               sop;
        logic [2*WIDTH-1:0] prod;
        logic               ovf;
    } vec_t;

    typedef struct {
        logic [2*WIDTH-1:0] prod;
        logic               ovf;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic chk(input string name, input logic [2*WIDTH-1:0] act,
                       input logic [2*WIDTH-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Drive a request and hold start until an IDLE edge accepts it.
    task automatic launch(input vec_t v, output int waited);
        logic idle_seen;
        bit   accepted;
        exp_t e;
        multiplicand = v.a;
        multiplier   = v.b;
`ifdef MULT_SIGNED_EN
        signed_op    = v.sop;
`endif
        start     = 1'b1;
        waited    = 0;
        accepted  = 1'b0;
        idle_seen = !busy;
        while (!accepted && waited < 100) begin
            @(posedge clk); #1;
            waited++;
            if (idle_seen && busy) accepted = 1'b1;
            idle_seen = !busy;
        end
        start = 1'b0;
        if (!accepted) begin
            chk("accept_timeout", 64'(waited), 64'(0));
        end else begin
            e.prod = v.prod;
            e.ovf  = v.ovf;
            sb_q.push_back(e);
        end
    endtask

    // Wait for done while scrambling operand inputs; optionally pulse start
    // once in the middle of RUN. Done must appear WIDTH edges after acceptance
    // (cycle WIDTH+1 counting the start cycle as cycle 0).
    task automatic wait_done(input int poke_at);
        int   edges;
        exp_t e;
        edges = 0;
        while (!done && edges < 100) begin
            @(posedge clk); #1;
            edges++;
            multiplicand = $urandom;
            multiplier   = $urandom;
            start        = (edges == poke_at);
        end
        start = 1'b0;
        chk("done_latency", 64'(edges), 64'(WIDTH));
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 64'(1), 64'(0));
        end else begin
            e = sb_q.pop_front();
            chk("product", product, e.prod);
            chk("result_lo", 64'(result_lo), 64'(e.prod[WIDTH-1:0]));
            chk("overflow", 64'(overflow), 64'(e.ovf));
        end
    endtask

    initial begin
        int   waited;
        vec_t v;

        vecs.push_back('{a: 32'd3,          b: 32'd5,          sop: 1'b0, prod: 64'h0000_0000_0000_000F, ovf: 1'b0});
        vecs.push_back('{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  sop: 1'b0, prod: 64'hFFFF_FFFE_0000_0001, ovf: 1'b1});
        vecs.push_back('{a: 32'd0,          b: 32'h1234_5678,  sop: 1'b0, prod: 64'h0,                   ovf: 1'b0});
        vecs.push_back('{a: 32'hFFFF_FFFF,  b: 32'd1,          sop: 1'b0, prod: 64'h0000_0000_FFFF_FFFF, ovf: 1'b0});
        vecs.push_back('{a: 32'h0001_0000,  b: 32'h0001_0000,  sop: 1'b0, prod: 64'h0000_0001_0000_0000, ovf: 1'b1});
        vecs.push_back('{a: 32'h8000_0000,  b: 32'd2,          sop: 1'b0, prod: 64'h0000_0001_0000_0000, ovf: 1'b1});
        vecs.push_back('{a: 32'h1234_5678,  b: 32'h9ABC_DEF0,  sop: 1'b0, prod: 64'h0B00_EA4E_242D_2080, ovf: 1'b1});
`ifdef MULT_SIGNED_EN
        vecs.push_back('{a: 32'hFFFF_FFFD,  b: 32'd7,          sop: 1'b1, prod: 64'hFFFF_FFFF_FFFF_FFEB, ovf: 1'b0});
        vecs.push_back('{a: 32'h8000_0000,  b: 32'h8000_0000,  sop: 1'b1, prod: 64'h4000_0000_0000_0000, ovf: 1'b1});
        vecs.push_back('{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  sop: 1'b1, prod: 64'h0000_0000_0000_0001, ovf: 1'b0});
        vecs.push_back('{a: 32'hFFFF_FFFF,  b: 32'd2,          sop: 1'b0, prod: 64'h0000_0001_FFFF_FFFE, ovf: 1'b1});
        signed_op = 1'b0;
`endif

        reset        = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_product", product, 64'(0));
        chk("rst_result_lo", 64'(result_lo), 64'(0));
        chk("rst_overflow", 64'(overflow), 64'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        // Table: each op gets a spurious start at RUN cycle 10 that must be ignored.
        foreach (vecs[i]) begin
            launch(vecs[i], waited);
            chk("busy_after_accept", 64'(busy), 64'(1));
            wait_done(10);
            @(posedge clk); #1;
            chk("done_one_cycle", 64'(done), 64'(0));
            chk("busy_fall", 64'(busy), 64'(0));
        end

        // Back-to-back: second start held high through DONE, accepted on the
        // first IDLE edge (two edges after done is seen).
        v = '{a: 32'd2, b: 32'd2, sop: 1'b0, prod: 64'd4, ovf: 1'b0};
        launch(v, waited);
        wait_done(0);
        v = '{a: 32'd10, b: 32'd10, sop: 1'b0, prod: 64'd100, ovf: 1'b0};
        launch(v, waited);
        chk("b2b_accept_edge", 64'(waited), 64'(2));
        wait_done(0);

        // Asynchronous reset in the middle of RUN.
        v = '{a: 32'h0001_2345, b: 32'h0000_6789, sop: 1'b0, prod: 64'h0, ovf: 1'b0};
        launch(v, waited);
        repeat (16) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_done", 64'(done), 64'(0));
        chk("midrst_product", product, 64'(0));
        chk("midrst_overflow", 64'(overflow), 64'(0));
        sb_q.delete();
        #2;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("midrst_idle", 64'(busy), 64'(0));
        v = '{a: 32'd7, b: 32'd9, sop: 1'b0, prod: 64'd63, ovf: 1'b0};
        launch(v, waited);
        chk("post_rst_accept", 64'(waited), 64'(1));
        wait_done(0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
